// File: rtl/irs_pattern_sequencer_pkg.sv
// Shared definitions for the IRS pattern sequencer: state encoding, default
// geometry and the memory-depth sanity check used at elaboration.
package irs_seq_pkg;

  localparam int SEQ_DATA_W_DEF = 24;
  localparam int SEQ_ADDR_W_DEF = 5;
  localparam int SEQ_DEPTH_DEF  = 16;

  localparam int SEQ_STATE_W = 3;

  // Encoding kept as plain constants so older IRS blocks can share it.
  localparam logic [SEQ_STATE_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [SEQ_STATE_W-1:0] ST_STORE   = 3'd1;
  localparam logic [SEQ_STATE_W-1:0] ST_RD_ADDR = 3'd2;
  localparam logic [SEQ_STATE_W-1:0] ST_LOAD    = 3'd3;
  localparam logic [SEQ_STATE_W-1:0] ST_WAIT    = 3'd4;
  localparam logic [SEQ_STATE_W-1:0] ST_DONE    = 3'd5;

  function automatic bit seq_depth_ok(input int depth, input int addr_w);
    return (depth >= 1) && (depth <= (1 << addr_w));
  endfunction

endpackage

// File: rtl/irs_pattern_sequencer_if.sv
// UART-receive handshake, pattern-memory bus and SPI load/done strobes that
// connect the sequencer to its surroundings.
interface irs_seq_if
  import irs_seq_pkg::*;
#(
  parameter int DATA_W = SEQ_DATA_W_DEF,
  parameter int ADDR_W = SEQ_ADDR_W_DEF
) ();

  logic              rx_req_tgl;
  logic [DATA_W-1:0] rx_data;
  logic              rx_ack_tgl;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;

  logic              load_data;
  logic              done_send;

  modport master (
    input  rx_req_tgl,
    input  rx_data,
    output rx_ack_tgl,
    output mem_addr,
    output mem_we,
    output mem_wdata,
    output load_data,
    input  done_send
  );

  modport slave (
    output rx_req_tgl,
    output rx_data,
    input  rx_ack_tgl,
    input  mem_addr,
    input  mem_we,
    input  mem_wdata,
    input  load_data,
    output done_send
  );

endinterface

// File: rtl/irs_pattern_sequencer_toggle_sync.sv
// Multi-flop synchroniser for a toggle-encoded request crossing into the
// local clock domain; shared by the IRS CDC paths.
module toggle_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("toggle_sync: SYNC_STAGES must be at least 2");
  end

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/irs_pattern_sequencer.sv
// IRS pattern sequencer: stores UART words into the pattern memory and plays
// a programmable-length frame out to the SPI engine, once or looping.
module irs_pattern_sequencer
  import irs_seq_pkg::*;
#(
  parameter int DATA_W      = SEQ_DATA_W_DEF,
  parameter int ADDR_W      = SEQ_ADDR_W_DEF,
  parameter int DEPTH       = SEQ_DEPTH_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_div,
  input  logic              rst_n,
  input  logic              i_din_en_n,
  input  logic              i_start_n,
  input  logic              i_loop_mode,
  input  logic [ADDR_W-1:0] i_frame_last,
  irs_seq_if.master         bus,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic [ADDR_W:0]   o_word_count,
  output logic              o_overflow
);

  if (!seq_depth_ok(DEPTH, ADDR_W)) begin : g_bad_depth
    $error("irs_pattern_sequencer: DEPTH must be between 1 and 2**ADDR_W");
  end

  localparam logic [ADDR_W-1:0] LAST_MAX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   CNT_MAX  = (ADDR_W + 1)'(DEPTH);

  logic [SEQ_STATE_W-1:0] r_state;
  logic [ADDR_W-1:0]      r_wr_ptr;
  logic [ADDR_W-1:0]      r_rd_ptr;
  logic [ADDR_W-1:0]      r_last;
  logic                   r_loop;
  logic                   r_ack_tgl;
  logic [ADDR_W-1:0]      r_mem_addr;
  logic                   r_mem_we;
  logic [DATA_W-1:0]      r_mem_wdata;
  logic                   r_load_data;
  logic                   r_frame_done;
  logic [ADDR_W:0]        r_word_count;
  logic                   r_overflow;

  logic                   w_req_s;
  logic                   w_pending;
  logic [ADDR_W-1:0]      w_last_clamp;
  logic [ADDR_W-1:0]      w_rd_next;

  toggle_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk   (clk_div),
    .rst_n (rst_n),
    .i_d   (bus.rx_req_tgl),
    .o_q   (w_req_s)
  );

  // rx_data is held by the sender until it sees our ack, so no data sync.
  assign w_pending    = (w_req_s != r_ack_tgl);
  assign w_last_clamp = (i_frame_last > LAST_MAX) ? LAST_MAX : i_frame_last;
  assign w_rd_next    = r_rd_ptr + 1'b1;

  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_last       <= '0;
      r_loop       <= 1'b0;
      r_ack_tgl    <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_we     <= 1'b0;
      r_mem_wdata  <= '0;
      r_load_data  <= 1'b0;
      r_frame_done <= 1'b0;
      r_word_count <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_mem_we     <= 1'b0;
      r_load_data  <= 1'b0;
      r_frame_done <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (!i_din_en_n) begin
            r_state      <= ST_STORE;
            r_wr_ptr     <= '0;
            r_word_count <= '0;
            r_overflow   <= 1'b0;
          end else if (!i_start_n) begin
            r_state    <= ST_RD_ADDR;
            r_last     <= w_last_clamp;
            r_loop     <= i_loop_mode;
            r_rd_ptr   <= '0;
            r_mem_addr <= '0;
          end
        end

        ST_STORE: begin
          // A word arriving on the exit cycle is still committed.
          if (w_pending) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_wr_ptr;
            r_mem_wdata <= bus.rx_data;
            r_ack_tgl   <= ~r_ack_tgl;
            if (r_wr_ptr == LAST_MAX) begin
              r_wr_ptr   <= '0;
              r_overflow <= 1'b1;
            end else begin
              r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (r_word_count != CNT_MAX) begin
              r_word_count <= r_word_count + 1'b1;
            end
          end
          if (i_din_en_n) begin
            r_state <= ST_IDLE;
          end
        end

        ST_RD_ADDR: begin
          r_state     <= ST_LOAD;
          r_load_data <= 1'b1;
        end

        ST_LOAD: begin
          r_state <= ST_WAIT;
        end

        ST_WAIT: begin
          if (bus.done_send) begin
            if (r_rd_ptr < r_last) begin
              r_rd_ptr   <= w_rd_next;
              r_mem_addr <= w_rd_next;
              r_state    <= ST_RD_ADDR;
            end else begin
              r_frame_done <= 1'b1;
              if (r_loop && !i_start_n) begin
                r_rd_ptr   <= '0;
                r_mem_addr <= '0;
                r_state    <= ST_RD_ADDR;
              end else begin
                r_state <= ST_DONE;
              end
            end
          end
        end

        ST_DONE: begin
          // Requiring start_n to be released avoids an immediate retrigger.
          if (i_start_n) begin
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.rx_ack_tgl = r_ack_tgl;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.load_data  = r_load_data;

  assign o_busy       = (r_state != ST_IDLE);
  assign o_frame_done = r_frame_done;
  assign o_word_count = r_word_count;
  assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_irs_pattern_sequencer.sv
// Directed bench for irs_pattern_sequencer: store, overflow, single and looped
// playback, clamping, ignored done_send and asynchronous reset.
module tb_irs_pattern_sequencer;
  import irs_seq_pkg::*;

  localparam int DATA_W = 24;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 16;

  logic              clk_div;
  logic              rst_n;
  logic              din_en_n;
  logic              start_n;
  logic              loop_mode;
  logic [ADDR_W-1:0] frame_last;
  logic              busy;
  logic              frame_done;
  logic [ADDR_W:0]   word_count;
  logic              overflow;

  logic ds_spi = 1'b0;
  logic ds_man = 1'b0;
  logic spi_en = 1'b0;
  logic req    = 1'b0;

  irs_seq_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
  assign bus.done_send = ds_spi | ds_man;

  irs_pattern_sequencer #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (2)
  ) dut (
    .clk_div      (clk_div),
    .rst_n        (rst_n),
    .i_din_en_n   (din_en_n),
    .i_start_n    (start_n),
    .i_loop_mode  (loop_mode),
    .i_frame_last (frame_last),
    .bus          (bus),
    .o_busy       (busy),
    .o_frame_done (frame_done),
    .o_word_count (word_count),
    .o_overflow   (overflow)
  );

  initial begin
    clk_div = 1'b0;
    forever #5 clk_div = ~clk_div;
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Observer: memory model and event logs, sampled on the falling edge.
  logic [DATA_W-1:0] tb_mem [32] = '{default: '0};
  int we_cnt  = 0;
  int ld_cnt  = 0;
  int fd_cnt  = 0;
  int ack_cnt = 0;
  logic ack_prev = 1'b0;
  int wr_addr_q [$];
  int ld_addr_q [$];
  logic [DATA_W-1:0] ld_val_q [$];

  always @(negedge clk_div) begin
    if (bus.mem_we === 1'b1) begin
      tb_mem[bus.mem_addr] <= bus.mem_wdata;
      wr_addr_q.push_back(int'(bus.mem_addr));
      we_cnt <= we_cnt + 1;
    end
    if (bus.load_data === 1'b1) begin
      ld_addr_q.push_back(int'(bus.mem_addr));
      ld_val_q.push_back(tb_mem[bus.mem_addr]);
      ld_cnt <= ld_cnt + 1;
    end
    if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
    if (bus.rx_ack_tgl !== ack_prev) ack_cnt <= ack_cnt + 1;
    ack_prev <= bus.rx_ack_tgl;
  end

  // SPI model: done_send five cycles after each load strobe.
  initial begin
    forever begin
      @(negedge clk_div);
      if (spi_en && bus.load_data === 1'b1) begin
        repeat (5) @(negedge clk_div);
        ds_spi = 1'b1;
        @(negedge clk_div);
        ds_spi = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_div);
    #1;
  endtask

  task automatic send_word(input logic [DATA_W-1:0] d);
    int k;
    bus.rx_data    = d;
    req            = ~req;
    bus.rx_req_tgl = req;
    for (k = 0; k < 20; k++) begin
      tick(1);
      if (bus.rx_ack_tgl == req) break;
    end
    if (k == 20) check("ack_timeout", 32'(bus.rx_ack_tgl), 32'(req));
    tick(1);
  endtask

  task automatic wait_frames(input string tag, input int target, input int budget);
    for (int k = 0; k < budget && fd_cnt < target; k++) tick(1);
    check(tag, 32'(fd_cnt >= target), 32'd1);
  endtask

  task automatic wait_loads(input string tag, input int target, input int budget);
    for (int k = 0; k < budget && ld_cnt < target; k++) tick(1);
    check(tag, 32'(ld_cnt >= target), 32'd1);
  endtask

  int base_w, base_l, base_f, base_ack, base_we;

  initial begin
    rst_n = 1'b0; din_en_n = 1'b1; start_n = 1'b1; loop_mode = 1'b0;
    frame_last = '0; bus.rx_req_tgl = 1'b0; bus.rx_data = '0;
    repeat (3) @(posedge clk_div);
    #3;
    check("rst_busy",       32'(busy),           32'd0);
    check("rst_word_count", 32'(word_count),     32'd0);
    check("rst_overflow",   32'(overflow),       32'd0);
    check("rst_mem_addr",   32'(bus.mem_addr),   32'd0);
    check("rst_mem_we",     32'(bus.mem_we),     32'd0);
    check("rst_mem_wdata",  32'(bus.mem_wdata),  32'd0);
    check("rst_load_data",  32'(bus.load_data),  32'd0);
    check("rst_frame_done", 32'(frame_done),     32'd0);
    check("rst_ack",        32'(bus.rx_ack_tgl), 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(2);
    check("idle_busy", 32'(busy), 32'd0);

    // Three words into a fresh store session
    din_en_n = 1'b0;
    tick(2);
    check("store_busy", 32'(busy), 32'd1);
    base_w = wr_addr_q.size(); base_ack = ack_cnt;
    send_word(24'hA5A5A5);
    send_word(24'h000001);
    send_word(24'hFFFFFF);
    tick(1);
    check("t1_nwr",   32'(wr_addr_q.size() - base_w), 32'd3);
    check("t1_addr0", 32'(wr_addr_q[base_w]),     32'd0);
    check("t1_addr1", 32'(wr_addr_q[base_w + 1]), 32'd1);
    check("t1_addr2", 32'(wr_addr_q[base_w + 2]), 32'd2);
    check("t1_mem0",  32'(tb_mem[0]), 32'h00A5A5A5);
    check("t1_mem1",  32'(tb_mem[1]), 32'h00000001);
    check("t1_mem2",  32'(tb_mem[2]), 32'h00FFFFFF);
    check("t1_count", 32'(word_count), 32'd3);
    check("t1_acks",  32'(ack_cnt - base_ack), 32'd3);
    check("t1_ovf",   32'(overflow), 32'd0);
    din_en_n = 1'b1;
    tick(2);
    check("t1_idle", 32'(busy), 32'd0);

    // DEPTH+1 words: wrap to address 0, sticky overflow, saturated count
    din_en_n = 1'b0;
    tick(2);
    check("t2_count_clr", 32'(word_count), 32'd0);
    base_w = wr_addr_q.size();
    for (int i = 0; i <= DEPTH; i++) send_word(24'h000100 + 24'(i));
    tick(1);
    check("t2_nwr",    32'(wr_addr_q.size() - base_w), 32'd17);
    check("t2_addr15", 32'(wr_addr_q[base_w + 15]), 32'd15);
    check("t2_addr16", 32'(wr_addr_q[base_w + 16]), 32'd0);
    check("t2_mem0",   32'(tb_mem[0]),  32'h00000110);
    check("t2_mem15",  32'(tb_mem[15]), 32'h0000010F);
    check("t2_ovf",    32'(overflow),   32'd1);
    check("t2_count",  32'(word_count), 32'd16);
    din_en_n = 1'b1;
    tick(2);
    din_en_n = 1'b0;
    tick(2);
    check("t2_ovf_clr",   32'(overflow),   32'd0);
    check("t2_count_clr", 32'(word_count), 32'd0);
    din_en_n = 1'b1;
    tick(2);

    // Single frame of four words
    spi_en = 1'b1; frame_last = 5'd3; loop_mode = 1'b0;
    base_l = ld_cnt; base_f = fd_cnt;
    start_n = 1'b0;
    wait_frames("t3_frame_wait", base_f + 1, 200);
    tick(10);
    check("t3_nload", 32'(ld_cnt - base_l), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t3_addr%0d", i), 32'(ld_addr_q[base_l + i]), 32'(i));
    check("t3_val0", 32'(ld_val_q[base_l]),     32'h00000110);
    check("t3_val3", 32'(ld_val_q[base_l + 3]), 32'h00000103);
    check("t3_nframe", 32'(fd_cnt - base_f), 32'd1);
    check("t3_done_busy", 32'(busy), 32'd1);
    start_n = 1'b1;
    tick(2);
    check("t3_idle", 32'(busy), 32'd0);

    // Looping two-word frame, released during the fourth frame
    frame_last = 5'd1; loop_mode = 1'b1;
    base_l = ld_cnt; base_f = fd_cnt;
    start_n = 1'b0;
    wait_frames("t4_three_frames", base_f + 3, 300);
    wait_loads("t4_mid_frame", base_l + 7, 50);
    start_n = 1'b1; loop_mode = 1'b0;
    wait_frames("t4_last_frame", base_f + 4, 100);
    tick(10);
    check("t4_nload", 32'(ld_cnt - base_l), 32'd8);
    for (int i = 0; i < 8; i++)
      check($sformatf("t4_addr%0d", i), 32'(ld_addr_q[base_l + i]), 32'(i % 2));
    check("t4_nframe", 32'(fd_cnt - base_f), 32'd4);
    check("t4_idle", 32'(busy), 32'd0);

    // frame_last beyond DEPTH clamps to the last location
    frame_last = 5'd20;
    base_l = ld_cnt; base_f = fd_cnt;
    start_n = 1'b0;
    wait_frames("t5_frame_wait", base_f + 1, 400);
    tick(10);
    check("t5_nload", 32'(ld_cnt - base_l), 32'd16);
    check("t5_last_addr", 32'(ld_addr_q[base_l + 15]), 32'd15);
    check("t5_last_val",  32'(ld_val_q[base_l + 15]),  32'h0000010F);
    check("t5_nframe", 32'(fd_cnt - base_f), 32'd1);
    start_n = 1'b1;
    tick(2);

    // Stray done_send in IDLE and STORE
    spi_en = 1'b0;
    base_l = ld_cnt; base_f = fd_cnt; base_we = we_cnt;
    ds_man = 1'b1; tick(1); ds_man = 1'b0; tick(3);
    check("t5_idle_busy", 32'(busy), 32'd0);
    check("t5_idle_nload", 32'(ld_cnt - base_l), 32'd0);
    din_en_n = 1'b0; tick(2);
    ds_man = 1'b1; tick(1); ds_man = 1'b0; tick(3);
    check("t5_store_busy", 32'(busy), 32'd1);
    check("t5_store_nwe", 32'(we_cnt - base_we), 32'd0);
    check("t5_store_nload", 32'(ld_cnt - base_l), 32'd0);
    check("t5_store_nframe", 32'(fd_cnt - base_f), 32'd0);
    din_en_n = 1'b1; tick(2);

    // Asynchronous reset while waiting on the SPI engine
    spi_en = 1'b1; frame_last = 5'd3;
    base_l = ld_cnt;
    start_n = 1'b0;
    wait_loads("t6_second_load", base_l + 2, 60);
    tick(1);
    check("t6_pre_addr", 32'(bus.mem_addr), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_busy",  32'(busy),          32'd0);
    check("t6_addr",  32'(bus.mem_addr),  32'd0);
    check("t6_load",  32'(bus.load_data), 32'd0);
    check("t6_fdone", 32'(frame_done),    32'd0);
    start_n = 1'b1; spi_en = 1'b0;
    tick(8);
    rst_n = 1'b1;
    tick(2);
    check("t6_idle", 32'(busy), 32'd0);

    // Asynchronous reset with a word in flight through the synchroniser
    din_en_n = 1'b0; tick(2);
    base_we = we_cnt; base_l = ld_cnt; base_ack = ack_cnt;
    bus.rx_data = 24'h5A5A5A;
    req = ~req; bus.rx_req_tgl = req;
    tick(1);
    #1 rst_n = 1'b0;
    #1;
    check("t7_we",    32'(bus.mem_we),  32'd0);
    check("t7_busy",  32'(busy),        32'd0);
    check("t7_wdata", 32'(bus.mem_wdata), 32'd0);
    din_en_n = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(10);
    check("t7_nwe",   32'(we_cnt - base_we), 32'd0);
    check("t7_nload", 32'(ld_cnt - base_l),  32'd0);
    check("t7_nack",  32'(ack_cnt - base_ack), 32'd0);
    check("t7_idle",  32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
